sevenseg_scan_rx: RTL and testbench



---
 rtl/sevenseg_pkg.sv | 47 ++++
 rtl/seg7_to_code.sv | 33 +++
 rtl/sevenseg_scan_rx.sv | 191 +++++++++++++++++++
 tb/tb_sevenseg_scan_rx.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared 7-segment character codes, segment patterns and mode numbers.
// The transmitter and the scan receiver both use these tables.
package sevenseg_pkg;

  localparam logic [3:0] CODE_SPACE   = 4'd10;
  localparam logic [3:0] CODE_C       = 4'd11;
  localparam logic [3:0] CODE_O       = 4'd12;
  localparam logic [3:0] CODE_H       = 4'd13;
  localparam logic [3:0] CODE_UNKNOWN = 4'd15;

  localparam logic [3:0] RET_128_DEF = 4'd0;
  localparam logic [3:0] RET_64_DEF  = 4'd1;
  localparam logic [3:0] RET_32_DEF  = 4'd2;
  localparam logic [3:0] RET_16_DEF  = 4'd3;
  localparam logic [3:0] COCHLEA_DEF = 4'd4;
  localparam logic [3:0] DIRECT_DEF  = 4'd5;
  localparam logic [3:0] RET_128_ALT = 4'd6;
  localparam logic [3:0] RET_64_ALT  = 4'd7;
  localparam logic [3:0] RET_32_ALT  = 4'd8;
  localparam logic [3:0] RET_16_ALT  = 4'd9;
  localparam logic [3:0] COCHLEA_ALT = 4'd10;
  localparam logic [3:0] DIRECT_ALT  = 4'd11;
  localparam logic [3:0] LAST_VALUE  = DIRECT_ALT;

  // Segment patterns are abcdefg with segment-on = 0.
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b1100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0001100;
  localparam logic [6:0] SEG_SPACE = 7'b1111111;
  localparam logic [6:0] SEG_C     = 7'b1110010;
  localparam logic [6:0] SEG_O     = 7'b1100010;
  localparam logic [6:0] SEG_H     = 7'b1101000;

  // Packs digit codes so digit k lands in [4k+3:4k].
  function automatic logic [15:0] pack_digits(input logic [3:0] d0, input logic [3:0] d1,
                                              input logic [3:0] d2, input logic [3:0] d3);
    return {d3, d2, d1, d0};
  endfunction

endpackage

// File: rtl/seg7_to_code.sv
// Combinational abcdefg pattern to character code decoder; unknown
// patterns give CODE_UNKNOWN with known = 0.
module seg7_to_code
  import sevenseg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code,
  output logic       known
);

  always_comb begin
    code  = CODE_UNKNOWN;
    known = 1'b1;
    case (seg)
      SEG_0:     code = 4'd0;
      SEG_1:     code = 4'd1;
      SEG_2:     code = 4'd2;
      SEG_3:     code = 4'd3;
      SEG_4:     code = 4'd4;
      SEG_5:     code = 4'd5;
      SEG_6:     code = 4'd6;
      SEG_7:     code = 4'd7;
      SEG_8:     code = 4'd8;
      SEG_9:     code = 4'd9;
      SEG_SPACE: code = CODE_SPACE;
      SEG_C:     code = CODE_C;
      SEG_O:     code = CODE_O;
      SEG_H:     code = CODE_H;
      default:   known = 1'b0;
    endcase
  end

endmodule

// File: rtl/sevenseg_scan_rx.sv
// Receiver for the scanned 4-digit 7-segment bus: rebuilds frames, qualifies
// repeated frames and decodes the displayed text back into the mode number.
module sevenseg_scan_rx
  import sevenseg_pkg::*;
#(
  parameter int MODE_BITS      = 4,
  parameter int SETTLE_CYCLES  = 16,
  parameter int STABLE_FRAMES  = 2,
  parameter int TIMEOUT_CYCLES = 21'h1fffff
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           i_7seg,
  input  logic [3:0]           i_strobe,
  input  logic                 err_clr,
  output logic [15:0]          digits,
  output logic [3:0]           dp_n,
  output logic                 frame_valid,
  output logic [MODE_BITS-1:0] mode,
  output logic                 mode_valid,
  output logic                 mode_change,
  output logic                 link_lost,
  output logic                 strobe_err,
  output logic                 seg_err
);

  logic [7:0]  seg_s1, seg_s2;
  logic [3:0]  stb_s1, stb_s2, stb_s3;
  logic [7:0]  settle_cnt;
  logic        captured;
  logic [20:0] to_cnt;
  logic [15:0] slot_codes;
  logic [3:0]  slot_dp;
  logic [3:0]  mask;
  logic [19:0] prev_frame;
  logic [3:0]  match_cnt;
  logic        mode_seen;

  logic        stb_change, capture_en, stb_onehot, slot_we, expire;
  logic        strobe_bad, seg_bad, frame_done, frame_same, publish;
  logic [3:0]  seg_code;
  logic        seg_known;
  logic [15:0] new_codes;
  logic [3:0]  new_dp, new_mask, match_next;
  logic [19:0] new_frame;
  logic [3:0]  dec_base;
  logic        dec_ok;
  logic [MODE_BITS-1:0] dec_mode;

  seg7_to_code u_dec (
    .seg   (seg_s2[6:0]),
    .code  (seg_code),
    .known (seg_known)
  );

  assign stb_change = (stb_s2 != stb_s3);
  assign capture_en = (settle_cnt == 8'd0) && !captured && !stb_change;
  assign stb_onehot = (stb_s2 != 4'd0) && ((stb_s2 & (stb_s2 - 4'd1)) == 4'd0);
  assign slot_we    = capture_en && stb_onehot;
  assign strobe_bad = capture_en && (stb_s2 != 4'd0) && !stb_onehot;
  assign seg_bad    = slot_we && !seg_known;
  // A strobe change in the expiry cycle reloads the timer instead.
  assign expire     = (to_cnt == 21'd0) && !stb_change;

  always_comb begin
    new_codes = slot_codes;
    new_dp    = slot_dp;
    new_mask  = mask;
    if (slot_we) begin
      for (int k = 0; k < 4; k++) begin
        if (stb_s2[k]) begin
          new_codes[4*k +: 4] = seg_code;
          new_dp[k]           = seg_s2[7];
        end
      end
      new_mask = mask | stb_s2;
    end
  end

  assign new_frame  = {new_codes, new_dp};
  assign frame_done = slot_we && (new_mask == 4'hf);
  // match_cnt == 0 means there is no previous frame to compare against.
  assign frame_same = (match_cnt != 4'd0) && (new_frame == prev_frame);
  assign match_next = !frame_same ? 4'd1 :
                      (match_cnt == 4'(STABLE_FRAMES)) ? match_cnt : 4'(match_cnt + 4'd1);
  assign publish    = frame_done && (match_next == 4'(STABLE_FRAMES));

  always_comb begin
    dec_base = RET_128_DEF;
    dec_ok   = 1'b1;
    dec_mode = '0;
    case (new_codes)
      pack_digits(CODE_SPACE, 4'd1, 4'd2, 4'd8):           dec_base = RET_128_DEF;
      pack_digits(CODE_SPACE, CODE_SPACE, 4'd6, 4'd4):     dec_base = RET_64_DEF;
      pack_digits(CODE_SPACE, CODE_SPACE, 4'd3, 4'd2):     dec_base = RET_32_DEF;
      pack_digits(CODE_SPACE, CODE_SPACE, 4'd1, 4'd6):     dec_base = RET_16_DEF;
      pack_digits(CODE_C, CODE_O, CODE_C, CODE_H):         dec_base = COCHLEA_DEF;
      pack_digits(4'd0, 4'd0, 4'd0, 4'd0):                 dec_base = DIRECT_DEF;
      default:                                             dec_ok   = 1'b0;
    endcase
    if (new_dp == 4'b1110)
      dec_mode = MODE_BITS'(dec_base + (RET_128_ALT - RET_128_DEF));
    else if (new_dp == 4'b1111)
      dec_mode = MODE_BITS'(dec_base);
    else
      dec_ok = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_s1      <= '0;
      seg_s2      <= '0;
      stb_s1      <= '0;
      stb_s2      <= '0;
      stb_s3      <= '0;
      settle_cnt  <= '0;
      captured    <= 1'b0;
      to_cnt      <= '0;
      slot_codes  <= '0;
      slot_dp     <= '0;
      mask        <= '0;
      prev_frame  <= '0;
      match_cnt   <= '0;
      mode_seen   <= 1'b0;
      digits      <= '0;
      dp_n        <= 4'hf;
      frame_valid <= 1'b0;
      mode        <= '0;
      mode_valid  <= 1'b0;
      mode_change <= 1'b0;
      link_lost   <= 1'b1;
      strobe_err  <= 1'b0;
      seg_err     <= 1'b0;
    end else begin
      seg_s1 <= i_7seg;
      seg_s2 <= seg_s1;
      stb_s1 <= i_strobe;
      stb_s2 <= stb_s1;
      stb_s3 <= stb_s2;

      if (stb_change) begin
        settle_cnt <= 8'(SETTLE_CYCLES);
        captured   <= 1'b0;
        to_cnt     <= 21'(TIMEOUT_CYCLES);
      end else begin
        if (settle_cnt != 8'd0) settle_cnt <= settle_cnt - 8'd1;
        if (capture_en)         captured   <= 1'b1;
        if (to_cnt != 21'd0)    to_cnt     <= to_cnt - 21'd1;
      end

      mode_change <= 1'b0;
      if (expire) begin
        mask        <= '0;
        match_cnt   <= '0;
        link_lost   <= 1'b1;
        frame_valid <= 1'b0;
        mode_valid  <= 1'b0;
      end else if (slot_we) begin
        slot_codes <= new_codes;
        slot_dp    <= new_dp;
        if (frame_done) begin
          mask       <= '0;
          match_cnt  <= match_next;
          prev_frame <= new_frame;
          if (publish) begin
            digits      <= new_codes;
            dp_n        <= new_dp;
            frame_valid <= 1'b1;
            link_lost   <= 1'b0;
            if (dec_ok) begin
              mode        <= dec_mode;
              mode_valid  <= 1'b1;
              mode_seen   <= 1'b1;
              mode_change <= !mode_seen || (dec_mode != mode);
            end else begin
              mode_valid  <= 1'b0;
            end
          end
        end else begin
          mask <= new_mask;
        end
      end

      if (strobe_bad)   strobe_err <= 1'b1;
      else if (err_clr) strobe_err <= 1'b0;
      if (seg_bad)      seg_err    <= 1'b1;
      else if (err_clr) seg_err    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_rx.sv
// Directed bench for sevenseg_scan_rx: scans hand-built frames and checks
// published digits, mode, timeout and error flags against hand-computed values.
module tb_sevenseg_scan_rx;

  localparam int DWELL = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  i_7seg = 8'hff;
  logic [3:0]  i_strobe = 4'd0;
  logic        err_clr = 1'b0;
  logic [15:0] digits;
  logic [3:0]  dp_n;
  logic        frame_valid;
  logic [3:0]  mode;
  logic        mode_valid, mode_change, link_lost, strobe_err, seg_err;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q[$];

  sevenseg_scan_rx #(
    .MODE_BITS(4), .SETTLE_CYCLES(4), .STABLE_FRAMES(2), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk), .rst(rst), .i_7seg(i_7seg), .i_strobe(i_strobe), .err_clr(err_clr),
    .digits(digits), .dp_n(dp_n), .frame_valid(frame_valid), .mode(mode),
    .mode_valid(mode_valid), .mode_change(mode_change), .link_lost(link_lost),
    .strobe_err(strobe_err), .seg_err(seg_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every mode_change pulse must match the next expected mode
  always @(negedge clk) begin
    if (mode_change) begin
      if (exp_q.size() == 0) chk("mode_change_extra", 32'd1, 32'd0);
      else chk("mode_change_val", {28'd0, mode}, {28'd0, exp_q.pop_front()});
    end
  end

  function automatic logic [6:0] seg_of(input logic [3:0] c);
    case (c)
      4'd0:  return 7'b0000001;
      4'd1:  return 7'b1001111;
      4'd2:  return 7'b0010010;
      4'd3:  return 7'b0000110;
      4'd4:  return 7'b1001100;
      4'd5:  return 7'b0100100;
      4'd6:  return 7'b1100000;
      4'd7:  return 7'b0001111;
      4'd8:  return 7'b0000000;
      4'd9:  return 7'b0001100;
      4'd10: return 7'b1111111;
      4'd11: return 7'b1110010;
      4'd12: return 7'b1100010;
      4'd13: return 7'b1101000;
      default: return 7'b1010101;
    endcase
  endfunction

  // driver tasks
  task automatic send_strobe(input logic [3:0] stb, input logic [7:0] bus);
    @(negedge clk);
    i_strobe = stb;
    i_7seg   = bus;
    repeat (DWELL - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [3:0] c0, input logic [3:0] c1,
                            input logic [3:0] c2, input logic [3:0] c3,
                            input logic [3:0] dpn);
    send_strobe(4'b0001, {dpn[0], seg_of(c0)});
    send_strobe(4'b0010, {dpn[1], seg_of(c1)});
    send_strobe(4'b0100, {dpn[2], seg_of(c2)});
    send_strobe(4'b1000, {dpn[3], seg_of(c3)});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    i_strobe = 4'd0;
    i_7seg   = 8'hff;
    err_clr  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_digits", {16'd0, digits}, 32'h0);
    chk("rst_dp_n", {28'd0, dp_n}, 32'hf);
    chk("rst_link_lost", {31'd0, link_lost}, 32'd1);
    chk("rst_flags", {27'd0, frame_valid, mode_valid, mode_change, strobe_err, seg_err}, 32'd0);
    rst = 1'b0;

    // mode 0 "  128"
    exp_q.push_back(4'd0);
    send_frame(4'd10, 4'd1, 4'd2, 4'd8, 4'b1111);
    chk("m0_f1_no_publish", {31'd0, frame_valid}, 32'd0);
    send_frame(4'd10, 4'd1, 4'd2, 4'd8, 4'b1111);
    chk("m0_digits", {16'd0, digits}, 32'h821A);
    chk("m0_mode", {28'd0, mode}, 32'd0);
    chk("m0_mode_valid", {31'd0, mode_valid}, 32'd1);
    chk("m0_frame_valid", {31'd0, frame_valid}, 32'd1);
    chk("m0_link_alive", {31'd0, link_lost}, 32'd0);
    send_frame(4'd10, 4'd1, 4'd2, 4'd8, 4'b1111);
    chk("m0_single_pulse", exp_q.size(), 32'd0);

    // cochlea with digit 0 dp on -> mode 10
    exp_q.push_back(4'd10);
    send_frame(4'd11, 4'd12, 4'd11, 4'd13, 4'b1110);
    chk("coch_f1_hold_digits", {16'd0, digits}, 32'h821A);
    send_frame(4'd11, 4'd12, 4'd11, 4'd13, 4'b1110);
    chk("coch_mode", {28'd0, mode}, 32'd10);
    chk("coch_digits", {16'd0, digits}, 32'hDBCB);
    chk("coch_dp_n", {28'd0, dp_n}, 32'he);
    chk("coch_mode_valid", {31'd0, mode_valid}, 32'd1);

    // alternating frames never qualify
    do_reset();
    for (int i = 0; i < 2; i++) begin
      send_frame(4'd10, 4'd10, 4'd6, 4'd4, 4'b1111);
      send_frame(4'd10, 4'd10, 4'd3, 4'd2, 4'b1111);
    end
    chk("alt_frame_valid", {31'd0, frame_valid}, 32'd0);
    chk("alt_digits", {16'd0, digits}, 32'h0);
    chk("alt_mode_valid", {31'd0, mode_valid}, 32'd0);

    // timeout and recovery, mode 1
    do_reset();
    exp_q.push_back(4'd1);
    send_frame(4'd10, 4'd10, 4'd6, 4'd4, 4'b1111);
    send_frame(4'd10, 4'd10, 4'd6, 4'd4, 4'b1111);
    chk("to_mode", {28'd0, mode}, 32'd1);
    @(negedge clk);
    i_strobe = 4'd0;
    repeat (40) @(negedge clk);
    chk("to_not_yet", {31'd0, link_lost}, 32'd0);
    repeat (50) @(negedge clk);
    chk("to_link_lost", {31'd0, link_lost}, 32'd1);
    chk("to_frame_valid", {31'd0, frame_valid}, 32'd0);
    chk("to_mode_valid", {31'd0, mode_valid}, 32'd0);
    send_frame(4'd10, 4'd10, 4'd6, 4'd4, 4'b1111);
    chk("to_resume_f1", {31'd0, link_lost}, 32'd1);
    send_frame(4'd10, 4'd10, 4'd6, 4'd4, 4'b1111);
    chk("to_resume_f2", {31'd0, link_lost}, 32'd0);
    chk("to_resume_valid", {31'd0, frame_valid}, 32'd1);

    // illegal strobe
    do_reset();
    send_strobe(4'b0110, {1'b1, seg_of(4'd3)});
    chk("stb_err_set", {31'd0, strobe_err}, 32'd1);
    chk("stb_err_seg_clean", {31'd0, seg_err}, 32'd0);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
    chk("stb_err_clr", {31'd0, strobe_err}, 32'd0);

    // bad segment pattern in digit 2
    do_reset();
    for (int i = 0; i < 2; i++) begin
      send_strobe(4'b0001, {1'b1, seg_of(4'd10)});
      send_strobe(4'b0010, {1'b1, seg_of(4'd1)});
      send_strobe(4'b0100, {1'b1, 7'b1010101});
      send_strobe(4'b1000, {1'b1, seg_of(4'd8)});
    end
    chk("seg_err_set", {31'd0, seg_err}, 32'd1);
    chk("seg_digits", {16'd0, digits}, 32'h8F1A);
    chk("seg_mode_valid", {31'd0, mode_valid}, 32'd0);
    chk("seg_frame_valid", {31'd0, frame_valid}, 32'd1);

    // asynchronous reset mid-frame
    @(negedge clk);
    i_strobe = 4'b0001;
    i_7seg   = {1'b1, seg_of(4'd10)};
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_digits", {16'd0, digits}, 32'h0);
    chk("arst_dp_n", {28'd0, dp_n}, 32'hf);
    chk("arst_link_lost", {31'd0, link_lost}, 32'd1);
    chk("arst_flags", {27'd0, frame_valid, mode_valid, mode_change, strobe_err, seg_err}, 32'd0);
    chk("arst_mode", {28'd0, mode}, 32'd0);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
